// File: rtl/spi_reg_ctrl.sv
// SPI register-access controller: parses RX bytes into cmd/addr/data, drives a register bus
// and queues one TX byte per RX byte. Define SPI_REG_CTRL_AUTOINC_EN for burst auto-increment.
module spi_reg_ctrl #(
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       reg_wr_en,
    output logic [6:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_rd_en,
    output logic [6:0] reg_rd_addr,
    input  logic [7:0] reg_rd_data,
    output logic       stat_timeout
);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int LAT_W = 3;

    typedef enum logic [2:0] {
        S_CMD, S_RD_WAIT, S_TX, S_RD_NEXT, S_WR_DATA
    } state_t;

    state_t          r_state, w_state_next;
    logic [6:0]      r_addr, w_addr_next;
    logic            r_ret_rd, w_ret_rd_next;
    logic            r_wr_done, w_wr_done_next;
    logic [7:0]      r_tx_data, w_tx_data_next;
    logic [TO_W-1:0] r_to_cnt;
    logic [LAT_W-1:0] r_lat_cnt;
    logic            r_s_tready, r_m_tvalid;
    logic            r_wr_en, r_rd_en, r_stat_timeout;
    logic [6:0]      r_wr_addr, r_rd_addr;
    logic [7:0]      r_wr_data;
    logic            w_rx_hs, w_tx_hs, w_rd_stb, w_wr_stb, w_timeout;
    logic [6:0]      w_stb_addr;

    assign w_rx_hs = s_axis_tvalid & r_s_tready;
    assign w_tx_hs = r_m_tvalid & m_axis_tready;

    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_ret_rd_next  = r_ret_rd;
        w_wr_done_next = r_wr_done;
        w_tx_data_next = r_tx_data;
        w_stb_addr     = r_addr;
        w_rd_stb       = 1'b0;
        w_wr_stb       = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            S_CMD: begin
                if (w_rx_hs) begin
                    w_addr_next    = s_axis_tdata[6:0];
                    w_stb_addr     = s_axis_tdata[6:0];
                    w_wr_done_next = 1'b0;
                    if (s_axis_tdata[7]) begin
                        w_rd_stb     = 1'b1;
                        w_state_next = S_RD_WAIT;
                    end else begin
                        w_tx_data_next = 8'h00;
                        w_ret_rd_next  = 1'b0;
                        w_state_next   = S_TX;
                    end
                end
            end
            S_RD_WAIT: begin
                if (r_lat_cnt == LAT_W'(RD_LATENCY)) begin
                    w_tx_data_next = reg_rd_data;
                    w_ret_rd_next  = 1'b1;
                    w_state_next   = S_TX;
                end
            end
            S_TX: begin
                if (w_tx_hs)
                    w_state_next = r_ret_rd ? S_RD_NEXT : S_WR_DATA;
            end
            S_RD_NEXT: begin
                if (w_rx_hs) begin
`ifdef SPI_REG_CTRL_AUTOINC_EN
                    w_addr_next  = r_addr + 7'd1;
                    w_stb_addr   = r_addr + 7'd1;
                    w_rd_stb     = 1'b1;
                    w_state_next = S_RD_WAIT;
`else
                    w_tx_data_next = 8'h00;
                    w_state_next   = S_TX;
`endif
                end
            end
            S_WR_DATA: begin
                if (w_rx_hs) begin
                    w_tx_data_next = 8'h00;
                    w_state_next   = S_TX;
`ifdef SPI_REG_CTRL_AUTOINC_EN
                    w_wr_stb       = 1'b1;
                    w_addr_next    = r_addr + 7'd1;
`else
                    w_wr_stb       = ~r_wr_done;
                    w_wr_done_next = 1'b1;
`endif
                end
            end
            default: w_state_next = S_CMD;
        endcase
        // A handshake in the expiring cycle keeps the frame alive.
        if (r_state != S_CMD && !w_rx_hs && !w_tx_hs && r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            w_timeout    = 1'b1;
            w_state_next = S_CMD;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state        <= S_CMD;
            r_addr         <= 7'd0;
            r_ret_rd       <= 1'b0;
            r_wr_done      <= 1'b0;
            r_tx_data      <= 8'h00;
            r_to_cnt       <= '0;
            r_lat_cnt      <= '0;
            r_s_tready     <= 1'b0;
            r_m_tvalid     <= 1'b0;
            r_wr_en        <= 1'b0;
            r_rd_en        <= 1'b0;
            r_stat_timeout <= 1'b0;
            r_wr_addr      <= 7'd0;
            r_rd_addr      <= 7'd0;
            r_wr_data      <= 8'h00;
        end else begin
            r_state        <= w_state_next;
            r_addr         <= w_addr_next;
            r_ret_rd       <= w_ret_rd_next;
            r_wr_done      <= w_wr_done_next;
            r_tx_data      <= w_tx_data_next;
            r_stat_timeout <= w_timeout;
            r_rd_en        <= w_rd_stb;
            r_wr_en        <= w_wr_stb;
            r_s_tready     <= (w_state_next == S_CMD) || (w_state_next == S_RD_NEXT) ||
                              (w_state_next == S_WR_DATA);
            r_m_tvalid     <= (w_state_next == S_TX);
            if (w_rx_hs || w_tx_hs || w_state_next == S_CMD)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TO_W'(1);
            if (r_state == S_RD_WAIT && w_state_next == S_RD_WAIT)
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            else
                r_lat_cnt <= '0;
            if (w_rd_stb)
                r_rd_addr <= w_stb_addr;
            if (w_wr_stb) begin
                r_wr_addr <= w_stb_addr;
                r_wr_data <= s_axis_tdata;
            end
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tdata  = r_tx_data;
    assign m_axis_tvalid = r_m_tvalid;
    assign reg_wr_en     = r_wr_en;
    assign reg_wr_addr   = r_wr_addr;
    assign reg_wr_data   = r_wr_data;
    assign reg_rd_en     = r_rd_en;
    assign reg_rd_addr   = r_rd_addr;
    assign stat_timeout  = r_stat_timeout;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl with a behavioural register file (latency 1).
module tb_spi_reg_ctrl;
    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       reg_wr_en;
    logic [6:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [6:0] reg_rd_addr;
    logic [7:0] reg_rd_data;
    logic       stat_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    spi_reg_ctrl dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .stat_timeout(stat_timeout)
    );

    always #5 aclk = ~aclk;

    // Register file model: one-cycle read latency.
    logic [7:0] mem [128];
    always @(posedge aclk) begin
        if (reg_wr_en) mem[reg_wr_addr] <= reg_wr_data;
        if (reg_rd_en) reg_rd_data <= mem[reg_rd_addr];
    end

    // Event log, stamped with the edge number that ends the observed cycle.
    int         edge_n = 0;
    int         viol = 0;
    int         rx_e[$];
    int         tx_e[$];
    logic [7:0] tx_d[$];
    int         rd_e[$];
    logic [6:0] rd_a[$];
    int         wr_e[$];
    logic [6:0] wr_a[$];
    logic [7:0] wr_d[$];
    int         to_e[$];

    always @(posedge aclk) begin
        edge_n = edge_n + 1;
        if (s_axis_tvalid && s_axis_tready) rx_e.push_back(edge_n);
        if (m_axis_tvalid && m_axis_tready) begin tx_e.push_back(edge_n); tx_d.push_back(m_axis_tdata); end
        if (reg_rd_en) begin rd_e.push_back(edge_n); rd_a.push_back(reg_rd_addr); end
        if (reg_wr_en) begin wr_e.push_back(edge_n); wr_a.push_back(reg_wr_addr); wr_d.push_back(reg_wr_data); end
        if (stat_timeout) to_e.push_back(edge_n);
        if (reg_rd_en && reg_wr_en) viol = viol + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic clear_log();
        rx_e.delete(); tx_e.delete(); tx_d.delete(); rd_e.delete(); rd_a.delete();
        wr_e.delete(); wr_a.delete(); wr_d.delete(); to_e.delete();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        idle(2);
        areset = 1'b0;
        idle(1);
        clear_log();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (s_axis_tready !== 1'b1 && n < 100) begin
            @(posedge aclk); #1;
            n++;
        end
        if (s_axis_tready !== 1'b1) begin
            n_checks++;
            $display("FAIL send_byte_ready: tready=%b required 1", s_axis_tready);
        end else begin
            s_axis_tdata  = b;
            s_axis_tvalid = 1'b1;
            @(posedge aclk); #1;
            s_axis_tvalid = 1'b0;
        end
    endtask

    task automatic wait_timeout();
        for (int i = 0; i < 1200 && to_e.size() == 0; i++) begin
            @(posedge aclk); #1;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        idle(3);
        n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL rst_s_tready: got %b want 0", s_axis_tready); else n_pass++;
        n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_m_tvalid: got %b want 0", m_axis_tvalid); else n_pass++;
        n_checks++; if (m_axis_tdata !== 8'h00) $display("FAIL rst_m_tdata: got %h want 00", m_axis_tdata); else n_pass++;
        n_checks++; if (reg_wr_en !== 1'b0 || reg_rd_en !== 1'b0) $display("FAIL rst_strobes: wr=%b rd=%b want 0 0", reg_wr_en, reg_rd_en); else n_pass++;
        n_checks++; if (reg_wr_addr !== 7'h00 || reg_rd_addr !== 7'h00) $display("FAIL rst_addr: wr=%h rd=%h want 00 00", reg_wr_addr, reg_rd_addr); else n_pass++;
        n_checks++; if (reg_wr_data !== 8'h00) $display("FAIL rst_wr_data: got %h want 00", reg_wr_data); else n_pass++;
        n_checks++; if (stat_timeout !== 1'b0) $display("FAIL rst_timeout: got %b want 0", stat_timeout); else n_pass++;
        areset = 1'b0;
        idle(1);
        n_checks++; if (s_axis_tready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", s_axis_tready); else n_pass++;
        clear_log();
        $display("test_reset done");
    endtask

    task automatic test_write();
        do_reset();
        send_byte(8'h05); idle(4);
        send_byte(8'hA5); idle(6);
        n_checks++; if (wr_e.size() != 1) $display("FAIL wr_count: got %0d want 1", wr_e.size()); else n_pass++;
        if (wr_e.size() >= 1 && rx_e.size() == 2) begin
            n_checks++; if (wr_a[0] !== 7'h05 || wr_d[0] !== 8'hA5) $display("FAIL wr_addr_data: got %h=%h want 05=a5", wr_a[0], wr_d[0]); else n_pass++;
            n_checks++; if (wr_e[0] - rx_e[1] != 1) $display("FAIL wr_latency: got %0d want 1", wr_e[0] - rx_e[1]); else n_pass++;
        end
        n_checks++; if (tx_e.size() != 2) $display("FAIL wr_tx_count: got %0d want 2", tx_e.size()); else n_pass++;
        if (tx_e.size() == 2 && rx_e.size() == 2) begin
            n_checks++; if (tx_d[0] !== 8'h00 || tx_d[1] !== 8'h00) $display("FAIL wr_tx_data: got %h %h want 00 00", tx_d[0], tx_d[1]); else n_pass++;
            n_checks++; if (tx_e[0] - rx_e[0] != 1) $display("FAIL wr_tx_latency: got %0d want 1", tx_e[0] - rx_e[0]); else n_pass++;
        end
        n_checks++; if (rd_e.size() != 0) $display("FAIL wr_no_read: got %0d want 0", rd_e.size()); else n_pass++;
        $display("test_write: 0x05 <= 0xA5, %0d writes, %0d tx bytes", wr_e.size(), tx_e.size());
    endtask

    task automatic test_read();
        do_reset(); send_byte(8'h12); idle(4); send_byte(8'h3C); idle(6);
        do_reset(); send_byte(8'h13); idle(4); send_byte(8'h5A); idle(6);
        do_reset();
        send_byte(8'h92); idle(6);
        send_byte(8'hFF); idle(8);
        if (rd_e.size() >= 1 && rx_e.size() == 2) begin
            n_checks++; if (rd_a[0] !== 7'h12) $display("FAIL rd_addr: got %h want 12", rd_a[0]); else n_pass++;
            n_checks++; if (rd_e[0] - rx_e[0] != 1) $display("FAIL rd_strobe_latency: got %0d want 1", rd_e[0] - rx_e[0]); else n_pass++;
        end
        n_checks++; if (tx_e.size() != 2) $display("FAIL rd_tx_count: got %0d want 2", tx_e.size()); else n_pass++;
        if (tx_e.size() == 2 && rx_e.size() == 2) begin
            n_checks++; if (tx_d[0] !== 8'h3C) $display("FAIL rd_tx_data: got %h want 3c", tx_d[0]); else n_pass++;
            n_checks++; if (tx_e[0] - rx_e[0] != 3) $display("FAIL rd_tx_latency: got %0d want 3", tx_e[0] - rx_e[0]); else n_pass++;
`ifdef SPI_REG_CTRL_AUTOINC_EN
            n_checks++; if (tx_d[1] !== 8'h5A) $display("FAIL rd_burst_data: got %h want 5a", tx_d[1]); else n_pass++;
        end
        n_checks++; if (rd_e.size() != 2) $display("FAIL rd_count: got %0d want 2", rd_e.size()); else n_pass++;
        if (rd_e.size() == 2) begin
            n_checks++; if (rd_a[1] !== 7'h13) $display("FAIL rd_burst_addr: got %h want 13", rd_a[1]); else n_pass++;
        end
`else
            n_checks++; if (tx_d[1] !== 8'h00) $display("FAIL rd_dummy_data: got %h want 00", tx_d[1]); else n_pass++;
        end
        n_checks++; if (rd_e.size() != 1) $display("FAIL rd_count: got %0d want 1", rd_e.size()); else n_pass++;
`endif
        $display("test_read: 0x12 -> %0d reads, %0d tx bytes", rd_e.size(), tx_e.size());
    endtask

    task automatic test_burst_wrap();
        logic [7:0] bytes [4];
        bytes[0] = 8'h7E; bytes[1] = 8'h11; bytes[2] = 8'h22; bytes[3] = 8'h33;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i]); idle(4);
        end
        idle(4);
        n_checks++; if (tx_e.size() != 4) $display("FAIL burst_tx_count: got %0d want 4", tx_e.size()); else n_pass++;
        for (int i = 0; i < tx_e.size() && i < 4; i++) begin
            n_checks++; if (tx_d[i] !== 8'h00) $display("FAIL burst_tx_data[%0d]: got %h want 00", i, tx_d[i]); else n_pass++;
        end
`ifdef SPI_REG_CTRL_AUTOINC_EN
        n_checks++; if (wr_e.size() != 3) $display("FAIL burst_wr_count: got %0d want 3", wr_e.size()); else n_pass++;
        if (wr_e.size() == 3) begin
            n_checks++; if (wr_a[0] !== 7'h7E || wr_d[0] !== 8'h11) $display("FAIL burst_wr0: got %h=%h want 7e=11", wr_a[0], wr_d[0]); else n_pass++;
            n_checks++; if (wr_a[1] !== 7'h7F || wr_d[1] !== 8'h22) $display("FAIL burst_wr1: got %h=%h want 7f=22", wr_a[1], wr_d[1]); else n_pass++;
            n_checks++; if (wr_a[2] !== 7'h00 || wr_d[2] !== 8'h33) $display("FAIL burst_wr2: got %h=%h want 00=33", wr_a[2], wr_d[2]); else n_pass++;
        end
`else
        n_checks++; if (wr_e.size() != 1) $display("FAIL burst_wr_count: got %0d want 1", wr_e.size()); else n_pass++;
        if (wr_e.size() == 1) begin
            n_checks++; if (wr_a[0] !== 7'h7E || wr_d[0] !== 8'h11) $display("FAIL burst_wr0: got %h=%h want 7e=11", wr_a[0], wr_d[0]); else n_pass++;
        end
`endif
        $display("test_burst_wrap: %0d writes, %0d tx bytes", wr_e.size(), tx_e.size());
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'h01);
        wait_timeout();
        n_checks++; if (to_e.size() != 1) $display("FAIL to_pulse: got %0d pulses want 1", to_e.size()); else n_pass++;
        if (to_e.size() == 1 && rx_e.size() == 1) begin
            n_checks++; if (to_e[0] - rx_e[0] != 1026) $display("FAIL to_latency: got %0d want 1026", to_e[0] - rx_e[0]); else n_pass++;
        end
        n_checks++; if (s_axis_tready !== 1'b1) $display("FAIL to_back_in_cmd: tready=%b want 1", s_axis_tready); else n_pass++;
        n_checks++; if (wr_e.size() != 0) $display("FAIL to_no_write: got %0d want 0", wr_e.size()); else n_pass++;
        send_byte(8'h81); idle(6);
        n_checks++; if (rd_e.size() != 1) $display("FAIL to_resync_read: got %0d reads want 1", rd_e.size()); else n_pass++;
        if (rd_e.size() == 1) begin
            n_checks++; if (rd_a[0] !== 7'h01) $display("FAIL to_resync_addr: got %h want 01", rd_a[0]); else n_pass++;
        end
        $display("test_timeout: %0d pulses, resync reads %0d", to_e.size(), rd_e.size());
    endtask

    task automatic test_backpressure();
        do_reset();
        m_axis_tready = 1'b0;
        send_byte(8'hA0);
        wait_timeout();
        n_checks++; if (to_e.size() != 1) $display("FAIL bp_pulse: got %0d pulses want 1", to_e.size()); else n_pass++;
        if (to_e.size() == 1 && rx_e.size() == 1) begin
            n_checks++; if (to_e[0] - rx_e[0] != 1025) $display("FAIL bp_latency: got %0d want 1025", to_e[0] - rx_e[0]); else n_pass++;
        end
        n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL bp_tvalid_dropped: got %b want 0", m_axis_tvalid); else n_pass++;
        m_axis_tready = 1'b1;
        idle(5);
        n_checks++; if (tx_e.size() != 0) $display("FAIL bp_no_tx: got %0d want 0", tx_e.size()); else n_pass++;
        $display("test_backpressure: %0d pulses, %0d tx bytes", to_e.size(), tx_e.size());
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'hB0);
        n_checks++; if (reg_rd_en !== 1'b1 || reg_rd_addr !== 7'h30) $display("FAIL mid_rd_strobe: rd_en=%b addr=%h want 1 30", reg_rd_en, reg_rd_addr); else n_pass++;
        areset = 1'b1;
        idle(1);
        n_checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00) $display("FAIL mid_tx: tvalid=%b tdata=%h want 0 00", m_axis_tvalid, m_axis_tdata); else n_pass++;
        n_checks++; if (reg_rd_en !== 1'b0 || reg_rd_addr !== 7'h00 || s_axis_tready !== 1'b0) $display("FAIL mid_outputs: rd_en=%b rd_addr=%h tready=%b want 0 00 0", reg_rd_en, reg_rd_addr, s_axis_tready); else n_pass++;
        idle(2);
        areset = 1'b0;
        idle(8);
        n_checks++; if (tx_e.size() != 0) $display("FAIL mid_no_tx: got %0d want 0", tx_e.size()); else n_pass++;
        n_checks++; if (rd_e.size() != 1) $display("FAIL mid_no_more_reads: got %0d want 1", rd_e.size()); else n_pass++;
        $display("test_reset_mid: %0d tx bytes after abort", tx_e.size());
    endtask

    task automatic test_exclusive_strobes();
        n_checks++; if (viol != 0) $display("FAIL rd_wr_same_cycle: got %0d cycles want 0", viol); else n_pass++;
        $display("test_exclusive_strobes: %0d overlapping cycles", viol);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_burst_wrap();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_exclusive_strobes();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
